// File: rtl/mips_multicycle_datapath.sv
// ---------------------------------------------------------------------------
// mips_multicycle_datapath
//
// Multicycle MIPS datapath. It holds the architectural and inter-stage
// registers (PC, IR, MDR, A, B, ALUOut), a 32x32 register file and the ALU.
// It executes the per-state control word supplied by an external controller
// and hands back the opcode, funct and ALU zero flag for sequencing.
// Instruction and data traffic share one memory port. Reads from that port
// are combinational. Memory writes happen outside this block, on the clock
// edge, using adr and writedata.
//
// Ports
//   clk         in   1   system clock, all state updates on the rising edge
//   reset       in   1   synchronous, active-high reset
//   memtoreg    in   1   register write data: 1=MDR, 0=ALUOut
//   pcEn        in   1   PC load enable
//   pcsrc       in   1   next PC: 0=ALU result (this cycle), 1=ALUOut
//   alusrcA     in   1   ALU operand A: 0=PC, 1=A register
//   alusrcB     in   2   ALU operand B: 00=B, 01=PC_INC, 10=SignImm, 11=SignImm<<2
//   regdst      in   1   write register: 1=IR[15:11], 0=IR[20:16]
//   regwrite    in   1   register file write enable
//   IRwrite     in   1   IR load enable
//   IorD        in   1   memory address: 0=PC, 1=ALUOut
//   alucontrol  in   3   010 add, 110 sub, 000 and, 001 or, 111 slt
//   readdata    in   32  memory read data, valid in the same cycle as adr
//   op          out  6   IR[31:26]
//   funct       out  6   IR[5:0]
//   zero        out  1   combinational ALU result == 0
//   adr         out  32  memory address
//   writedata   out  32  memory write data (B register)
// ---------------------------------------------------------------------------
module mips_multicycle_datapath #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] PC_INC   = 32'd4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        memtoreg,
  input  logic        pcEn,
  input  logic        pcsrc,
  input  logic        alusrcA,
  input  logic [1:0]  alusrcB,
  input  logic        regdst,
  input  logic        regwrite,
  input  logic        IRwrite,
  input  logic        IorD,
  input  logic [2:0]  alucontrol,
  input  logic [31:0] readdata,
  output logic [5:0]  op,
  output logic [5:0]  funct,
  output logic        zero,
  output logic [31:0] adr,
  output logic [31:0] writedata
);

  // ALU operation encodings driven by the controller.
  localparam logic [2:0] ALU_AND = 3'b000;
  localparam logic [2:0] ALU_OR  = 3'b001;
  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_SUB = 3'b110;
  localparam logic [2:0] ALU_SLT = 3'b111;

  logic [31:0] pc, ir, mdr, a, b, aluout;
  logic [31:0] rf [32];

  logic [4:0]  ra1, ra2, wa;
  logic [31:0] rd1, rd2, wd;
  logic [31:0] sign_imm, src_a, src_b, alu_result, pc_next;

  // ---------------------------------------------------------------------
  // Instruction field decode
  // ---------------------------------------------------------------------
  assign op       = ir[31:26];
  assign funct    = ir[5:0];
  assign ra1      = ir[25:21];
  assign ra2      = ir[20:16];
  assign wa       = regdst ? ir[15:11] : ir[20:16];
  assign wd       = memtoreg ? mdr : aluout;
  assign sign_imm = {{16{ir[15]}}, ir[15:0]};

  // ---------------------------------------------------------------------
  // Register file: two combinational read ports, one synchronous write port
  // ---------------------------------------------------------------------
  // R0 is forced to zero on the read side. Its storage word is never written.
  // A read of the register being written returns the old contents, because
  // the new value only lands at the edge.
  assign rd1 = (ra1 == 5'd0) ? 32'd0 : rf[ra1];
  assign rd2 = (ra2 == 5'd0) ? 32'd0 : rf[ra2];

  // NOTE: the register array has no reset. Clearing it would turn the
  // storage into 1024 resettable flops. Software initialises registers
  // before it reads them, and R0 is zeroed on the read side.
  always_ff @(posedge clk) begin
    if (!reset && regwrite && (wa != 5'd0)) begin
      rf[wa] <= wd;
    end
  end

  // ---------------------------------------------------------------------
  // ALU operand selection and ALU
  // ---------------------------------------------------------------------
  assign src_a = alusrcA ? a : pc;

  // NOTE: each always_comb assigns a default before its case statement.
  // This prevents an unlisted selector value from inferring a latch and
  // keeps every output defined.
  always_comb begin
    src_b = b;
    case (alusrcB)
      2'b00:   src_b = b;
      2'b01:   src_b = PC_INC;
      2'b10:   src_b = sign_imm;
      2'b11:   src_b = {sign_imm[29:0], 2'b00};
      default: src_b = b;
    endcase
  end

  always_comb begin
    alu_result = 32'd0;
    case (alucontrol)
      ALU_ADD: alu_result = src_a + src_b;
      ALU_SUB: alu_result = src_a - src_b;
      ALU_AND: alu_result = src_a & src_b;
      ALU_OR:  alu_result = src_a | src_b;
      ALU_SLT: alu_result = {31'd0, ($signed(src_a) < $signed(src_b))};
      default: alu_result = 32'd0;
    endcase
  end

  // During the branch state the controller samples zero from the live ALU
  // result, not from ALUOut.
  assign zero    = (alu_result == 32'd0);
  assign pc_next = pcsrc ? aluout : alu_result;

  // ---------------------------------------------------------------------
  // Datapath registers
  // ---------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments only. Each edge
  // therefore samples the previous values of every register. For example,
  // A and B capture the pre-write register file contents, and the PC is
  // loaded from the pre-edge ALUOut.
  always_ff @(posedge clk) begin
    if (reset) begin
      pc     <= RESET_PC;
      ir     <= 32'd0;
      mdr    <= 32'd0;
      a      <= 32'd0;
      b      <= 32'd0;
      aluout <= 32'd0;
    end else begin
      mdr    <= readdata;
      a      <= rd1;
      b      <= rd2;
      aluout <= alu_result;
      if (IRwrite) ir <= readdata;
      if (pcEn)    pc <= pc_next;
    end
  end

  assign adr       = IorD ? aluout : pc;
  assign writedata = b;

endmodule

// File: tb/tb_mips_multicycle_datapath.sv
// ---------------------------------------------------------------------------
// tb_mips_multicycle_datapath
//
// Self-checking bench for the multicycle MIPS datapath. Each cycle the
// stimulus pushes the expected observable values (adr, writedata, op, funct,
// zero) to a scoreboard queue. The queue is drained and compared either
// #1 after the next rising edge or #1 after the inputs change, for
// combinational checks.
// ---------------------------------------------------------------------------
module tb_mips_multicycle_datapath;

  logic        clk;
  logic        reset;
  logic        memtoreg, pcEn, pcsrc, alusrcA, regdst, regwrite, IRwrite, IorD;
  logic [1:0]  alusrcB;
  logic [2:0]  alucontrol;
  logic [31:0] readdata;
  logic [5:0]  op, funct;
  logic        zero;
  logic [31:0] adr, writedata;

  mips_multicycle_datapath dut (
    .clk        (clk),
    .reset      (reset),
    .memtoreg   (memtoreg),
    .pcEn       (pcEn),
    .pcsrc      (pcsrc),
    .alusrcA    (alusrcA),
    .alusrcB    (alusrcB),
    .regdst     (regdst),
    .regwrite   (regwrite),
    .IRwrite    (IRwrite),
    .IorD       (IorD),
    .alucontrol (alucontrol),
    .readdata   (readdata),
    .op         (op),
    .funct      (funct),
    .zero       (zero),
    .adr        (adr),
    .writedata  (writedata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef enum logic [2:0] {O_ADR, O_WD, O_OP, O_FUNCT, O_ZERO} obs_e;
  typedef struct {
    obs_e        sel;
    string       tag;
    logic [31:0] exp;
  } exp_t;

  exp_t        sb[$];
  int          tests_run = 0;
  int          tests_failed = 0;
  logic [31:0] pc_model;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic expect_obs(input obs_e sel, input string tag, input logic [31:0] val);
    exp_t e;
    e.sel = sel;
    e.tag = tag;
    e.exp = val;
    sb.push_back(e);
  endtask

  task automatic drain();
    exp_t        e;
    logic [31:0] got;
    while (sb.size() > 0) begin
      e = sb.pop_front();
      case (e.sel)
        O_ADR:   got = adr;
        O_WD:    got = writedata;
        O_OP:    got = {26'd0, op};
        O_FUNCT: got = {26'd0, funct};
        default: got = {31'd0, zero};
      endcase
      check(e.tag, got, e.exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    drain();
  endtask

  task automatic settle();
    #1;
    drain();
  endtask

  task automatic idle();
    memtoreg   = 1'b0;
    pcEn       = 1'b0;
    pcsrc      = 1'b0;
    alusrcA    = 1'b0;
    alusrcB    = 2'b00;
    regdst     = 1'b0;
    regwrite   = 1'b0;
    IRwrite    = 1'b0;
    IorD       = 1'b0;
    alucontrol = 3'b010;
    readdata   = 32'd0;
  endtask

  task automatic load_ir(input logic [31:0] word);
    idle();
    readdata = word;
    IRwrite  = 1'b1;
    tick();
    idle();
  endtask

  // Writes val to register r through the MDR path. The IR rt field selects r.
  task automatic write_reg(input logic [4:0] r, input logic [31:0] val);
    load_ir({6'd0, 5'd0, r, 16'd0});
    readdata = val;
    tick();
    idle();
    regwrite = 1'b1;
    memtoreg = 1'b1;
    tick();
    idle();
  endtask

  task automatic read_b(input logic [4:0] r, input logic [31:0] exp, input string tag);
    load_ir({6'd0, 5'd0, r, 16'd0});
    expect_obs(O_WD, tag, exp);
    tick();
  endtask

  function automatic logic [31:0] alu_model(input logic [2:0] ctl, input logic [31:0] x,
                                            input logic [31:0] y);
    case (ctl)
      3'b010:  return x + y;
      3'b110:  return x - y;
      3'b000:  return x & y;
      3'b001:  return x | y;
      3'b111:  return ($signed(x) < $signed(y)) ? 32'd1 : 32'd0;
      default: return 32'd0;
    endcase
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    // ---------------- reset with pcEn/IRwrite/regwrite asserted ---------
    idle();
    reset      = 1'b1;
    pcEn       = 1'b1;
    IRwrite    = 1'b1;
    regwrite   = 1'b1;
    alusrcB    = 2'b01;
    readdata   = 32'hFFFF_FFFF;
    for (int i = 0; i < 2; i++) begin
      expect_obs(O_ADR,   "reset_adr",   32'd0);
      expect_obs(O_OP,    "reset_op",    32'd0);
      expect_obs(O_FUNCT, "reset_funct", 32'd0);
      expect_obs(O_WD,    "reset_wd",    32'd0);
      tick();
    end
    idle();
    reset = 1'b0;
    expect_obs(O_ADR, "release_adr", 32'd0);
    settle();
    pc_model = 32'd0;

    // ---------------- fetch lw $t0,4($0) --------------------------------
    readdata = 32'h8C08_0004;
    IRwrite  = 1'b1;
    alusrcB  = 2'b01;
    pcEn     = 1'b1;
    pc_model = pc_model + 32'd4;
    expect_obs(O_ADR,   "fetch_pc",    pc_model);
    expect_obs(O_OP,    "fetch_op",    32'h23);
    expect_obs(O_FUNCT, "fetch_funct", 32'h04);
    tick();

    // ---------------- lw address, memory read, writeback ----------------
    idle();
    alusrcA = 1'b1;
    alusrcB = 2'b10;
    tick();
    idle();
    IorD = 1'b1;
    expect_obs(O_ADR, "lw_adr", 32'd4);
    settle();
    readdata = 32'hDEAD_BEEF;
    tick();
    idle();
    regwrite = 1'b1;
    memtoreg = 1'b1;
    tick();
    idle();
    read_b(5'd8, 32'hDEAD_BEEF, "lw_rf8");

    // ---------------- add $t2,$t0,$t1 -----------------------------------
    write_reg(5'd8, 32'd5);
    write_reg(5'd9, 32'hFFFF_FFF9);
    load_ir({6'd0, 5'd8, 5'd9, 5'd10, 5'd0, 6'h20});
    expect_obs(O_WD,    "add_b",     32'hFFFF_FFF9);
    expect_obs(O_FUNCT, "add_funct", 32'h20);
    tick();
    alusrcA = 1'b1;
    tick();
    idle();
    regwrite = 1'b1;
    regdst   = 1'b1;
    tick();
    idle();
    read_b(5'd10, 32'hFFFF_FFFE, "add_rf10");

    // ---------------- slt both operand orders ---------------------------
    load_ir({6'd0, 5'd8, 5'd9, 5'd10, 5'd0, 6'h2a});
    tick();
    alusrcA    = 1'b1;
    alucontrol = 3'b111;
    IorD       = 1'b1;
    expect_obs(O_ZERO, "slt_zero", 32'd1);
    settle();
    expect_obs(O_ADR, "slt_5_lt_m7", 32'd0);
    tick();
    load_ir({6'd0, 5'd9, 5'd8, 5'd10, 5'd0, 6'h2a});
    tick();
    alusrcA    = 1'b1;
    alucontrol = 3'b111;
    IorD       = 1'b1;
    expect_obs(O_ZERO, "slt_swap_zero", 32'd0);
    settle();
    expect_obs(O_ADR, "slt_m7_lt_5", 32'd1);
    tick();

    // ---------------- beq taken, offset -1 loops to itself --------------
    write_reg(5'd11, 32'd3);
    write_reg(5'd12, 32'd3);
    idle();
    readdata = {6'h04, 5'd11, 5'd12, 16'hFFFF};
    IRwrite  = 1'b1;
    alusrcB  = 2'b01;
    pcEn     = 1'b1;
    expect_obs(O_ADR, "beq_fetch_pc", pc_model + 32'd4);
    expect_obs(O_OP,  "beq_op",       32'h04);
    tick();
    idle();
    alusrcB = 2'b11;
    tick();
    idle();
    alusrcA    = 1'b1;
    alucontrol = 3'b110;
    expect_obs(O_ZERO, "beq_zero", 32'd1);
    settle();
    pcEn  = 1'b1;
    pcsrc = 1'b1;
    expect_obs(O_ADR, "beq_target", pc_model);
    expect_obs(O_WD,  "beq_b",      32'd3);
    tick();
    idle();

    // ---------------- R0 is hardwired to zero ---------------------------
    write_reg(5'd0, 32'h0000_1234);
    read_b(5'd0, 32'd0, "r0_read");

    // ---------------- write and read the same register in one cycle -----
    write_reg(5'd5, 32'h0000_1111);
    load_ir({6'd0, 5'd5, 5'd5, 16'd0});
    readdata = 32'h0000_2222;
    expect_obs(O_WD, "rw_pre", 32'h0000_1111);
    tick();
    idle();
    regwrite = 1'b1;
    memtoreg = 1'b1;
    expect_obs(O_WD, "rw_b_old", 32'h0000_1111);
    tick();
    idle();
    alusrcA = 1'b1;
    alusrcB = 2'b10;
    IorD    = 1'b1;
    expect_obs(O_WD,  "rw_b_new", 32'h0000_2222);
    expect_obs(O_ADR, "rw_a_old", 32'h0000_1111);
    tick();
    expect_obs(O_ADR, "rw_a_new", 32'h0000_2222);
    tick();
    idle();

    // ---------------- randomised ALU / operand-select sweep -------------
    for (int it = 0; it < 6; it++) begin
      logic [31:0] x, y, sx, r, sa, sbv;
      logic [15:0] imm;
      x   = $urandom;
      y   = (it == 0) ? x : $urandom;
      imm = 16'($urandom_range(0, 65535));
      sx  = {{16{imm[15]}}, imm};
      write_reg(5'd1, x);
      write_reg(5'd2, y);
      load_ir({6'd0, 5'd1, 5'd2, imm});
      tick();
      for (int k = 0; k < 12; k++) begin
        idle();
        IorD = 1'b1;
        if (k < 8) begin
          alusrcA    = 1'b1;
          alusrcB    = 2'b00;
          alucontrol = 3'(k);
        end else if (k < 11) begin
          alusrcA    = 1'b0;
          alusrcB    = 2'(k - 7);
          alucontrol = 3'b010;
        end else begin
          alusrcA    = 1'b1;
          alusrcB    = 2'b11;
          alucontrol = 3'b110;
        end
        sa = alusrcA ? x : pc_model;
        case (alusrcB)
          2'b00:   sbv = y;
          2'b01:   sbv = 32'd4;
          2'b10:   sbv = sx;
          default: sbv = {sx[29:0], 2'b00};
        endcase
        r = alu_model(alucontrol, sa, sbv);
        expect_obs(O_ZERO, $sformatf("sweep%0d_%0d_zero", it, k), {31'd0, (r == 32'd0)});
        settle();
        expect_obs(O_ADR, $sformatf("sweep%0d_%0d_alu", it, k), r);
        tick();
      end
    end

    idle();
    expect_obs(O_ADR, "final_pc", pc_model);
    settle();

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
